ex_mem_pipe_reg: RTL
====================

EX_MEM_PIPE_REG -- requirements
Module: ex_mem_pipe_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of result and store-data fields.
REQ-002 Parameter REG_W, default 5: width of destination register index.
REQ-003 Parameter FLUSH_EN, default 1: 1 = flush input honoured; 0 = flush ignored.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  EX stage presents an instruction.
REQ-007 in_ready  out  1  block can accept this cycle.
REQ-008 in_result, in_write_data  in  DATA_W each  ALU result, store data.
REQ-009 in_rd  in  REG_W  destination register.
REQ-010 in_memread, in_memwrite, in_memtoreg, in_regwrite  in  1 each  control bits.
REQ-011 flush  in  1  discard all held entries (branch/exception).
REQ-012 out_valid  out  1  head entry valid toward MEM.
REQ-013 out_ready  in  1  MEM consumes head this cycle.
REQ-014 out_result, out_write_data, out_rd, out_memread, out_memwrite, out_memtoreg, out_regwrite  out  widths as inputs  head entry fields.
REQ-015 fwd_rd  out  REG_W, fwd_regwrite  out  1  head destination for the forwarding unit.
REQ-016 occupancy  out  2  number of valid entries, 0..2.

Function
REQ-017 The block SHALL hold two entries, head (drives outputs) and skid; the skid is never valid while the head is empty.
REQ-018 Accept occurs when in_valid && in_ready; drain occurs when out_valid && out_ready.
REQ-019 in_ready SHALL be registered and equal to !skid_valid; it has no combinational path from out_ready.
REQ-020 Latency: an accept into an empty block SHALL give out_valid=1 and the payload on outputs the next cycle.
REQ-021 With out_ready held at 1 and in_valid held at 1, throughput SHALL be one instruction per cycle in order, and occupancy SHALL stay at 1.
REQ-022 Accept with no drain and head full: the payload SHALL go to skid, occupancy becomes 2, and in_ready falls next cycle.
REQ-023 Drain with skid full: skid SHALL move to head; any simultaneous accept SHALL go to skid.
REQ-024 Drain and accept in the same cycle with occupancy 1: the new payload SHALL replace head, and occupancy stays 1.
REQ-025 Order SHALL be strictly FIFO, with no duplication or loss.
REQ-026 Flush (FLUSH_EN=1) SHALL clear both valid bits at the next edge and SHALL override any same-cycle accept; in_ready becomes 1 and occupancy becomes 0.
REQ-027 Bubble gating: out_memread, out_memwrite and out_regwrite SHALL be 0 whenever out_valid=0, regardless of stored bits.
REQ-028 $0 rule: out_regwrite and fwd_regwrite SHALL be 0 when out_rd == 0.
REQ-029 fwd_rd SHALL equal out_rd, and fwd_regwrite SHALL equal out_regwrite.
REQ-030 Data fields of invalid entries are don't-care; control outputs are not (REQ-027).

Reset
REQ-031 On rst=1, asynchronously: both valid bits 0, occupancy 0, in_ready 1, and all out_* data and control fields 0.
REQ-032 Reset mid-operation SHALL discard all entries; the first accept after release behaves as into an empty block.

Structure
REQ-033 A shared package ex_mem_pkg SHALL define the control-bit struct (memread, memwrite, memtoreg, regwrite) and default widths DATA_W_DEF=32 and REG_W_DEF=5.
REQ-034 One sub-module, pipe_slot (valid bit plus payload register, load and clear inputs), SHALL be instantiated twice, as head and skid.
REQ-035 All state SHALL be in clk-edge or rst-edge processes; output gating is combinational only.

Verification
REQ-036 Reset with in_valid=1, then release -> out_valid=0 and in_ready=1; the first accept of result=0x0000_00AA gives out_result=0xAA one cycle later.
REQ-037 Stream of 8 instructions with out_ready=1 -> 8 outputs in order on consecutive cycles, occupancy constantly 1.
REQ-038 out_ready=0 for 3 cycles while sending A, B, C -> A in head, B in skid, in_ready=0 and C held; raise out_ready -> outputs A, B, C in order.
REQ-039 Occupancy 2 plus flush plus a simultaneous accept -> next cycle out_valid=0, occupancy 0, out_memwrite=0, and the accepted item is discarded.
REQ-040 Accept with rd=0 and regwrite=1 -> out_regwrite=0 and fwd_regwrite=0; with rd=5 -> both are 1 and fwd_rd=5.
REQ-041 rst asserted between clock edges at occupancy 2 -> outputs clear immediately without waiting for a clock edge.

Source files
------------

// File: rtl/ex_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_pkg
// Description : Shared types and default widths for the EX/MEM pipeline
//               register. Defines the MEM/WB control-bit bundle carried
//               alongside each instruction.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  // Control bits that travel with an instruction from EX into MEM/WB.
  typedef struct packed {
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic regwrite;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage
`default_nettype wire

// File: rtl/ex_mem_pipe_reg_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One storage slot of the EX/MEM skid buffer: a valid bit plus
//               a payload register. Clear has priority over load.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               i_load       - capture i_data and set valid
//               i_clear      - drop valid (payload kept, it is don't-care)
//               i_data       - payload to capture
//               o_valid      - slot holds a live entry
//               o_data       - stored payload (zero after reset)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/ex_mem_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_pipe_reg
// Description : EX/MEM pipeline register built as a two-entry skid buffer
//               (head drives MEM, skid absorbs one extra instruction while
//               MEM stalls). in_ready is a flop so no combinational path
//               runs from out_ready back to EX. Control outputs are gated
//               so bubbles never write memory or registers.
// Ports       : clk, rst                  - clock, async active-high reset
//               in_valid / in_ready       - EX-side handshake
//               in_result, in_write_data  - ALU result, store data
//               in_rd, in_mem*/in_regwrite- destination and control bits
//               flush                     - discard all held entries
//               out_valid / out_ready     - MEM-side handshake
//               out_*                     - head entry fields (gated ctrl)
//               fwd_rd, fwd_regwrite      - head destination for forwarding
//               occupancy                 - live entries, 0..2
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_pipe_reg
  import ex_mem_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_W    = REG_W_DEF,
  parameter int FLUSH_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_write_data,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic              in_memtoreg,
  input  logic              in_regwrite,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_write_data,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic              out_memtoreg,
  output logic              out_regwrite,
  output logic [REG_W-1:0]  fwd_rd,
  output logic              fwd_regwrite,
  output logic [1:0]        occupancy
);

  localparam int PAYLOAD_W = 2 * DATA_W + REG_W + CTRL_W;

  ctrl_t                 w_in_ctrl;
  ctrl_t                 w_head_ctrl;
  logic [PAYLOAD_W-1:0]  w_in_payload;
  logic [PAYLOAD_W-1:0]  w_head_data;
  logic [PAYLOAD_W-1:0]  w_skid_data;
  logic [PAYLOAD_W-1:0]  w_head_load_data;
  logic                  w_head_valid;
  logic                  w_skid_valid;
  logic                  w_accept;
  logic                  w_drain;
  logic                  w_flush;
  logic                  w_head_load;
  logic                  w_head_clear;
  logic                  w_skid_load;
  logic                  w_skid_clear;
  logic                  w_skid_valid_nxt;
  logic                  w_rd_nonzero;
  logic                  r_in_ready;

  assign w_in_ctrl    = '{memread:  in_memread,
                          memwrite: in_memwrite,
                          memtoreg: in_memtoreg,
                          regwrite: in_regwrite};
  assign w_in_payload = {in_result, in_write_data, in_rd, w_in_ctrl};

  assign w_flush  = (FLUSH_EN != 0) && flush;
  assign w_accept = in_valid && r_in_ready;
  assign w_drain  = w_head_valid && out_ready;

  // Head refills either from skid (when skid holds the next-oldest entry)
  // or straight from the input when it is empty or being drained.
  assign w_head_load      = (w_drain && w_skid_valid) ||
                            (w_accept && (!w_head_valid || w_drain));
  assign w_head_load_data = w_skid_valid ? w_skid_data : w_in_payload;
  assign w_head_clear     = w_flush || (w_drain && !w_skid_valid && !w_accept);

  // Skid only takes an entry when the head is full and stays full.
  assign w_skid_load  = w_accept && w_head_valid && !w_drain;
  assign w_skid_clear = w_flush || (w_drain && w_skid_valid);

  // Mirror of the skid slot's next valid state, so in_ready can be a flop.
  always_comb begin
    w_skid_valid_nxt = w_skid_valid;
    if (w_skid_clear)     w_skid_valid_nxt = 1'b0;
    else if (w_skid_load) w_skid_valid_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_in_ready <= 1'b1;
    else     r_in_ready <= !w_skid_valid_nxt;
  end

  pipe_slot #(.W(PAYLOAD_W)) u_head (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_head_load),
    .i_clear (w_head_clear),
    .i_data  (w_head_load_data),
    .o_valid (w_head_valid),
    .o_data  (w_head_data)
  );

  pipe_slot #(.W(PAYLOAD_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (w_in_payload),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  assign {out_result, out_write_data, out_rd, w_head_ctrl} = w_head_data;

  // Bubbles and writes to register zero must never reach MEM/WB.
  assign w_rd_nonzero = |out_rd;
  assign out_valid    = w_head_valid;
  assign out_memread  = w_head_valid && w_head_ctrl.memread;
  assign out_memwrite = w_head_valid && w_head_ctrl.memwrite;
  assign out_memtoreg = w_head_ctrl.memtoreg;
  assign out_regwrite = w_head_valid && w_head_ctrl.regwrite && w_rd_nonzero;

  assign fwd_rd       = out_rd;
  assign fwd_regwrite = out_regwrite;

  assign in_ready  = r_in_ready;
  assign occupancy = {1'b0, w_head_valid} + {1'b0, w_skid_valid};

endmodule
`default_nettype wire
